// File: rtl/rx_byte_assembler_pkg.sv
// Shared definitions for the USB RX byte assembly path.
// Holds the assembler state type and the SYNC / bit-stuffing defaults that
// the RX control FSM also relies on.
package rx_pkg;

  // Final SYNC byte as seen after LSB-first assembly (KJKJKJKK -> 0x80).
  localparam logic [7:0]  RX_SYNC_PATTERN = 8'h80;

  // Run length of 1s after which the transmitter inserts a stuffed 0.
  localparam int unsigned RX_MAX_ONES     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR  = 2'd2
  } rx_asm_state_t;

endpackage

// File: rtl/rx_bit_unstuffer.sv
// Bit-stuffing tracker for the RX byte assembler.
// Counts consecutive 1s on accepted bit strobes and flags the stuffed-bit slot.
//   clk, rst        : clock, synchronous active-high reset
//   d_bit           : current decoded bit
//   strobe          : advance the run counter with d_bit
//   clear           : zero the run counter (has priority over strobe)
//   bit_keep        : 0 when the current bit sits in the stuffed-bit slot
//   stuff_violation : current bit is a 1 in the stuffed-bit slot
module rx_bit_unstuffer
  import rx_pkg::*;
#(
  parameter int unsigned MAX_ONES = RX_MAX_ONES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_bit,
  input  logic strobe,
  input  logic clear,
  output logic bit_keep,
  output logic stuff_violation
);

  localparam int unsigned OW = $clog2(MAX_ONES + 1);

  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic          stuff_slot;

  always_comb begin
    stuff_slot      = (ones_cnt_q == OW'(MAX_ONES));
    bit_keep        = !stuff_slot;
    stuff_violation = stuff_slot && d_bit;

    ones_cnt_d = ones_cnt_q;
    if (clear) begin
      ones_cnt_d = '0;
    end else if (strobe) begin
      // A 0 always ends the run (including a dropped stuffed 0); a 1 in the
      // slot leaves the counter saturated.
      if (!d_bit) begin
        ones_cnt_d = '0;
      end else if (!stuff_slot) begin
        ones_cnt_d = ones_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_q <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end

endmodule

// File: rtl/rx_byte_assembler.sv
// USB RX byte assembler.
// Takes the NRZI-decoded bit stream, hunts for SYNC, strips stuffed bits and
// assembles LSB-first bytes. All outputs are registered, one clock after the
// shift_en strobe that caused them.
//   clk, rst     : clock, synchronous active-high reset
//   d_orig       : decoded bit, valid with shift_en
//   shift_en     : one strobe per bit period
//   eop          : end-of-packet, qualified by shift_en
//   rx_data      : last assembled byte (held until the next byte_valid)
//   byte_valid   : pulse, rx_data updated
//   packet_start : pulse, SYNC recognised
//   eop_ok       : pulse, EOP on a byte boundary
//   align_err    : pulse, EOP with a partial byte pending
//   stuff_err    : pulse, 1 received in a stuffed-bit slot
//   rx_active    : high while in DATA or ERR
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int unsigned            DATA_W       = 8,
  parameter logic [DATA_W-1:0]      SYNC_PATTERN = DATA_W'(RX_SYNC_PATTERN),
  parameter int unsigned            MAX_ONES     = RX_MAX_ONES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_orig,
  input  logic              shift_en,
  input  logic              eop,
  output logic [DATA_W-1:0] rx_data,
  output logic              byte_valid,
  output logic              packet_start,
  output logic              eop_ok,
  output logic              align_err,
  output logic              stuff_err,
  output logic              rx_active
);

  localparam int unsigned       CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W - 1);

  rx_asm_state_t     state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              packet_start_q, packet_start_d;
  logic              eop_ok_q, eop_ok_d;
  logic              align_err_q, align_err_d;
  logic              stuff_err_q, stuff_err_d;
  logic              rx_active_q, rx_active_d;

  logic              us_strobe, us_clear;
  logic              bit_keep, stuff_violation;
  logic [DATA_W-1:0] shifted;

  // The run counter also tracks the hunt stream in IDLE. SYNC ends in 0,1,
  // so it already holds exactly 1 when the match fires.
  rx_bit_unstuffer #(
    .MAX_ONES (MAX_ONES)
  ) u_unstuffer (
    .clk             (clk),
    .rst             (rst),
    .d_bit           (d_orig),
    .strobe          (us_strobe),
    .clear           (us_clear),
    .bit_keep        (bit_keep),
    .stuff_violation (stuff_violation)
  );

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    bit_cnt_d      = bit_cnt_q;
    rx_data_d      = rx_data_q;
    byte_valid_d   = 1'b0;
    packet_start_d = 1'b0;
    eop_ok_d       = 1'b0;
    align_err_d    = 1'b0;
    stuff_err_d    = 1'b0;
    us_strobe      = 1'b0;
    us_clear       = 1'b0;
    shifted        = {d_orig, sr_q[DATA_W-1:1]};

    case (state_q)
      IDLE: begin
        if (shift_en) begin
          if (eop) begin
            sr_d      = '0;
            bit_cnt_d = '0;
            us_clear  = 1'b1;
          end else begin
            us_strobe = 1'b1;
            sr_d      = shifted;
            // In IDLE bit_cnt counts hunt bits since the last clear
            // (saturating), so a match needs a full byte of real bits
            // rather than matching against the cleared zeros.
            if (bit_cnt_q == CNT_MAX && shifted == SYNC_PATTERN) begin
              state_d        = DATA;
              packet_start_d = 1'b1;
              bit_cnt_d      = '0;
            end else if (bit_cnt_q != CNT_MAX) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end

      DATA: begin
        if (shift_en) begin
          if (eop) begin
            if (bit_cnt_q == '0) begin
              eop_ok_d = 1'b1;
            end else begin
              align_err_d = 1'b1;
            end
            state_d   = IDLE;
            sr_d      = '0;
            bit_cnt_d = '0;
            us_clear  = 1'b1;
          end else begin
            us_strobe = 1'b1;
            if (stuff_violation) begin
              stuff_err_d = 1'b1;
              state_d     = ERR;
            end else if (bit_keep) begin
              sr_d = shifted;
              if (bit_cnt_q == CNT_MAX) begin
                rx_data_d    = shifted;
                byte_valid_d = 1'b1;
                bit_cnt_d    = '0;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
          end
        end
      end

      ERR: begin
        if (shift_en && eop) begin
          state_d   = IDLE;
          sr_d      = '0;
          bit_cnt_d = '0;
          us_clear  = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        sr_d      = '0;
        bit_cnt_d = '0;
        us_clear  = 1'b1;
      end
    endcase

    rx_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      bit_cnt_q      <= '0;
      rx_data_q      <= '0;
      byte_valid_q   <= 1'b0;
      packet_start_q <= 1'b0;
      eop_ok_q       <= 1'b0;
      align_err_q    <= 1'b0;
      stuff_err_q    <= 1'b0;
      rx_active_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_data_q      <= rx_data_d;
      byte_valid_q   <= byte_valid_d;
      packet_start_q <= packet_start_d;
      eop_ok_q       <= eop_ok_d;
      align_err_q    <= align_err_d;
      stuff_err_q    <= stuff_err_d;
      rx_active_q    <= rx_active_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign byte_valid   = byte_valid_q;
  assign packet_start = packet_start_q;
  assign eop_ok       = eop_ok_q;
  assign align_err    = align_err_q;
  assign stuff_err    = stuff_err_q;
  assign rx_active    = rx_active_q;

endmodule
